elc_call_scheduler: RTL and testbench

- Collects floor calls (hall and cab buttons) for the one-hot 8-floor elevator controller.
- Decides the next stop with a SCAN (keep direction while calls remain ahead) policy.
- Drives the controller's requested floor, then sequences arrive -> door dwell -> next stop.
- Sits between the button inputs and the elevator controller; consumes its current-floor, complete and alert outputs.

---
 rtl/elc_call_scheduler.sv | 216 +++++++++++++++++++++
 tb/tb_elc_call_scheduler.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/elc_call_scheduler.sv
// elc_call_scheduler
//   Collects hall/cab floor calls for the one-hot 8-floor elevator controller
//   and picks the next stop with a SCAN policy: keep the committed direction
//   while calls remain ahead, otherwise reverse. It then sequences
//   travel -> arrival -> door dwell -> next decision.
//
//   Optional build macro: ELC_SCHED_PARKING_EN
//     When defined, an idle timer requests a trip to floor 0 after
//     PARK_CYCLES idle cycles. When undefined, the scheduler idles indefinitely.
//
// Ports
//   clk          in   clock
//   reset        in   synchronous, active-high reset
//   call_in      in   [FLOORS] call pulses, bit i = floor i (multi-hot allowed)
//   cur_floor    in   [FLOORS] one-hot current floor from the controller
//   arrived      in   controller "complete" flag
//   door_hold    in   door/weight alert; freezes the dwell counter
//   target_floor out  [FLOORS] one-hot stop request
//   target_valid out  target_floor is live
//   dir_up       out  committed travel direction, 1 = up
//   pending      out  [FLOORS] latched outstanding calls
//   dwell        out  door-open phase active
//   idle         out  scheduler parked in IDLE
module elc_call_scheduler #(
  parameter int FLOORS       = 8,
  parameter int DWELL_CYCLES = 16,
  parameter int PARK_CYCLES  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FLOORS-1:0] call_in,
  input  logic [FLOORS-1:0] cur_floor,
  input  logic              arrived,
  input  logic              door_hold,
  output logic [FLOORS-1:0] target_floor,
  output logic              target_valid,
  output logic              dir_up,
  output logic [FLOORS-1:0] pending,
  output logic              dwell,
  output logic              idle
);

  localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CW-1:0]     DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [FLOORS-1:0] ONE        = {{(FLOORS-1){1'b0}}, 1'b1};

  if (DWELL_CYCLES < 1 || PARK_CYCLES < 1) begin : g_bad_params
    $error("elc_call_scheduler: DWELL_CYCLES and PARK_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_SELECT, ST_MOVE, ST_DWELL} state_t;

  state_t            state, state_n;
  logic [FLOORS-1:0] pending_n, target_n, set_mask, clr_mask, park_set;
  logic              valid_n, dir_n, dwell_n;
  logic [CW-1:0]     dwell_cnt, cnt_n;
  logic              cur_ok;
  logic [FLOORS-1:0] above, below, between, retarget;

  // Isolate the lowest / highest set bit of a floor vector (zero if none).
  function automatic logic [FLOORS-1:0] lowest_bit(input logic [FLOORS-1:0] v);
    logic [FLOORS-1:0] r;
    r = '0;
    for (int i = FLOORS - 1; i >= 0; i--) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [FLOORS-1:0] highest_bit(input logic [FLOORS-1:0] v);
    logic [FLOORS-1:0] r;
    r = '0;
    for (int i = 0; i < FLOORS; i++) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  // For a one-hot v: all bits strictly above / strictly below it. The shift
  // drops the top floor to zero so its "above" mask is empty (no wrap).
  function automatic logic [FLOORS-1:0] above_mask(input logic [FLOORS-1:0] v);
    return ~((v << 1) - ONE);
  endfunction

  function automatic logic [FLOORS-1:0] below_mask(input logic [FLOORS-1:0] v);
    return v - ONE;
  endfunction

  assign cur_ok = (cur_floor != '0) && ((cur_floor & (cur_floor - ONE)) == '0);
  assign above  = pending & above_mask(cur_floor);
  assign below  = pending & below_mask(cur_floor);

  // Calls lying strictly between the car and its target, in travel direction.
  assign between  = dir_up ? (above & below_mask(target_floor))
                           : (below & above_mask(target_floor));
  assign retarget = dir_up ? lowest_bit(between) : highest_bit(between);

  assign idle = (state == ST_IDLE);

`ifdef ELC_SCHED_PARKING_EN
  localparam int PW = $clog2(PARK_CYCLES + 1);
  localparam logic [PW-1:0] PARK_LAST = PW'(PARK_CYCLES);
  logic [PW-1:0] park_cnt;

  // Saturating idle timer; any call or leaving IDLE restarts it.
  always_ff @(posedge clk) begin
    if (reset || state != ST_IDLE || call_in != '0) park_cnt <= '0;
    else if (park_cnt != PARK_LAST)                 park_cnt <= park_cnt + PW'(1);
  end

  assign park_set = (state == ST_IDLE && park_cnt == PARK_LAST && cur_floor != ONE)
                    ? ONE : '0;
`else
  assign park_set = '0;
`endif

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      pending      <= '0;
      target_floor <= '0;
      target_valid <= 1'b0;
      dir_up       <= 1'b1;
      dwell        <= 1'b0;
      dwell_cnt    <= '0;
    end else begin
      state        <= state_n;
      pending      <= pending_n;
      target_floor <= target_n;
      target_valid <= valid_n;
      dir_up       <= dir_n;
      dwell        <= dwell_n;
      dwell_cnt    <= cnt_n;
    end
  end

  // Next-state logic. Calls for the open-door floor are absorbed during
  // DWELL, and a stop's clear wins over a same-edge call for that floor.
  always_comb begin
    state_n  = state;
    target_n = target_floor;
    valid_n  = target_valid;
    dir_n    = dir_up;
    dwell_n  = dwell;
    cnt_n    = dwell_cnt;
    clr_mask = '0;
    set_mask = call_in | park_set;
    if (state == ST_DWELL) set_mask = set_mask & ~cur_floor;

    case (state)
      ST_IDLE: begin
        if (pending != '0) state_n = ST_SELECT;
      end
      ST_SELECT: begin
        if (cur_ok) begin
          if (dir_up && above != '0) begin
            target_n = lowest_bit(above);
            valid_n  = 1'b1;
            state_n  = ST_MOVE;
          end else if (below != '0) begin
            dir_n    = 1'b0;
            target_n = highest_bit(below);
            valid_n  = 1'b1;
            state_n  = ST_MOVE;
          end else if (above != '0) begin
            dir_n    = 1'b1;
            target_n = lowest_bit(above);
            valid_n  = 1'b1;
            state_n  = ST_MOVE;
          end else if (pending == cur_floor) begin
            clr_mask = cur_floor;
            dwell_n  = 1'b1;
            cnt_n    = DWELL_LAST;
            state_n  = ST_DWELL;
          end else begin
            state_n  = ST_IDLE;
          end
        end
      end
      ST_MOVE: begin
        if (cur_ok) begin
          if (arrived && cur_floor == target_floor) begin
            clr_mask = target_floor;
            valid_n  = 1'b0;
            dwell_n  = 1'b1;
            cnt_n    = DWELL_LAST;
            state_n  = ST_DWELL;
          end else if (between != '0) begin
            target_n = retarget;
          end
        end
      end
      ST_DWELL: begin
        if (!door_hold) begin
          if (dwell_cnt == '0) begin
            dwell_n = 1'b0;
            state_n = (pending != '0) ? ST_SELECT : ST_IDLE;
          end else begin
            cnt_n = dwell_cnt - CW'(1);
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    pending_n = (pending | set_mask) & ~clr_mask;
  end

endmodule

// File: tb/tb_elc_call_scheduler.sv
// tb_elc_call_scheduler
//   Self-checking bench for elc_call_scheduler: a table of directed vectors,
//   hand-written multi-cycle sequences (SCAN order, retarget, dwell hold,
//   reset mid-move) and a randomized run against a floor-index reference model
//   with a simple car model driving cur_floor/arrived.
module tb_elc_call_scheduler;

  localparam int FL    = 8;
  localparam int DWELL = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [FL-1:0] call_in = '0;
  logic [FL-1:0] cur_floor = 8'h01;
  logic          arrived = 1'b0;
  logic          door_hold = 1'b0;
  logic [FL-1:0] target_floor;
  logic          target_valid;
  logic          dir_up;
  logic [FL-1:0] pending;
  logic          dwell;
  logic          idle;

  int n_vec  = 0;
  int n_miss = 0;
  logic [FL-1:0] car = 8'h01;

  elc_call_scheduler #(.FLOORS(FL), .DWELL_CYCLES(DWELL), .PARK_CYCLES(64)) dut (
    .clk(clk), .reset(reset), .call_in(call_in), .cur_floor(cur_floor),
    .arrived(arrived), .door_hold(door_hold), .target_floor(target_floor),
    .target_valid(target_valid), .dir_up(dir_up), .pending(pending),
    .dwell(dwell), .idle(idle)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, then sample just after the rising edge.
  task automatic applyStimulus(input logic [FL-1:0] c, input logic [FL-1:0] cur,
                               input logic arr, input logic hold);
    call_in   = c;
    cur_floor = cur;
    arrived   = arr;
    door_hold = hold;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_pending"}, int'(pending), 0);
    checkOutput({tag, "_target"}, int'(target_floor), 0);
    checkOutput({tag, "_valid"}, int'(target_valid), 0);
    checkOutput({tag, "_dir"}, int'(dir_up), 1);
    checkOutput({tag, "_dwell"}, int'(dwell), 0);
    checkOutput({tag, "_idle"}, int'(idle), 1);
  endtask

  task automatic doReset();
    reset = 1'b1;
    car   = 8'h01;
    applyStimulus('0, car, 1'b0, 1'b0);
    applyStimulus('0, car, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  // Count door-open cycles; start_len already observed. Optional hold window.
  task automatic waitDwell(input int start_len, input int hold_at, input int hold_n,
                           input logic [FL-1:0] call_at_hold, output int len);
    len = start_len;
    for (int k = 0; k < 200; k++) begin
      applyStimulus((k == hold_at) ? call_at_hold : '0, car, 1'b0,
                    (k >= hold_at && k < hold_at + hold_n));
      if (dwell) len++;
      else break;
    end
  endtask

  task automatic waitTarget(input string name, input logic [FL-1:0] tf, input logic dir);
    for (int n = 0; n < 10 && !target_valid; n++) applyStimulus('0, car, 1'b0, 1'b0);
    checkOutput({name, "_valid"}, int'(target_valid), 1);
    checkOutput({name, "_target"}, int'(target_floor), int'(tf));
    checkOutput({name, "_dir"}, int'(dir_up), int'(dir));
  endtask

  task automatic finishTrip(input string name, input logic [FL-1:0] tf);
    int len;
    car = tf;
    applyStimulus('0, car, 1'b1, 1'b0);
    checkOutput({name, "_dwell"}, int'(dwell), 1);
    checkOutput({name, "_cleared"}, int'(pending & tf), 0);
    waitDwell(1, 0, 0, '0, len);
    checkOutput({name, "_dwell_len"}, len, DWELL);
  endtask

  // ---------------- reference model (floor indices) ----------------
  typedef enum {M_WAITING, M_DECIDING, M_TRAVEL, M_DOORS} mode_t;
  mode_t         m_mode;
  logic [FL-1:0] m_pend;
  int            m_tgt;
  logic          m_dir;
  int            m_left;

  function automatic int onehotIndex(input logic [FL-1:0] v);
    int cnt = 0;
    int idx = -1;
    for (int f = 0; f < FL; f++) if (v[f]) begin cnt++; idx = f; end
    return (cnt == 1) ? idx : -1;
  endfunction

  // First pending floor walking from 'from' in steps of 'step', stopping before 'stop'.
  function automatic int nearestPending(input logic [FL-1:0] p, input int from,
                                        input int step, input int stop);
    for (int f = from; f != stop && f >= 0 && f < FL; f += step) if (p[f]) return f;
    return -1;
  endfunction

  task automatic modelReset();
    m_mode = M_WAITING; m_pend = '0; m_tgt = -1; m_dir = 1'b1; m_left = 0;
  endtask

  task automatic modelStep(input logic [FL-1:0] c, input logic [FL-1:0] cur,
                           input logic arr, input logic hold);
    logic [FL-1:0] nxt;
    int ci, up, dn, clr, btw;
    ci  = onehotIndex(cur);
    clr = -1;
    nxt = m_pend;
    for (int f = 0; f < FL; f++)
      if (c[f] && !(m_mode == M_DOORS && cur[f])) nxt[f] = 1'b1;
    case (m_mode)
      M_WAITING: if (m_pend != '0) m_mode = M_DECIDING;
      M_DECIDING: if (ci >= 0) begin
        up = nearestPending(m_pend, ci + 1, 1, FL);
        dn = nearestPending(m_pend, ci - 1, -1, -1);
        if (m_dir && up >= 0)       begin m_tgt = up; m_mode = M_TRAVEL; end
        else if (dn >= 0)           begin m_tgt = dn; m_dir = 1'b0; m_mode = M_TRAVEL; end
        else if (up >= 0)           begin m_tgt = up; m_dir = 1'b1; m_mode = M_TRAVEL; end
        else if (m_pend[ci])        begin clr = ci; m_left = DWELL; m_mode = M_DOORS; end
        else                        m_mode = M_WAITING;
      end
      M_TRAVEL: if (ci >= 0) begin
        if (arr && ci == m_tgt) begin
          clr = ci; m_left = DWELL; m_mode = M_DOORS;
        end else begin
          btw = -1;
          if (m_dir && ci < m_tgt)       btw = nearestPending(m_pend, ci + 1, 1, m_tgt);
          else if (!m_dir && ci > m_tgt) btw = nearestPending(m_pend, ci - 1, -1, m_tgt);
          if (btw >= 0) m_tgt = btw;
        end
      end
      M_DOORS: if (!hold) begin
        m_left--;
        if (m_left == 0) m_mode = (m_pend != '0) ? M_DECIDING : M_WAITING;
      end
      default: ;
    endcase
    if (clr >= 0) nxt[clr] = 1'b0;
    m_pend = nxt;
  endtask

  task automatic checkModel();
    checkOutput("rand_pending", int'(pending), int'(m_pend));
    checkOutput("rand_valid", int'(target_valid), int'(m_mode == M_TRAVEL));
    checkOutput("rand_dir", int'(dir_up), int'(m_dir));
    checkOutput("rand_dwell", int'(dwell), int'(m_mode == M_DOORS));
    checkOutput("rand_idle", int'(idle), int'(m_mode == M_WAITING));
    if (m_mode == M_TRAVEL)
      checkOutput("rand_target", int'(target_floor), 1 << m_tgt);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [FL-1:0] call;
    logic [FL-1:0] cur;
    logic          arr;
    logic          hold;
    logic [FL-1:0] e_pend;
    logic [FL-1:0] e_tf;
    logic          e_tv;
    logic          e_dir;
    logic          e_dwell;
    logic          e_idle;
    logic          chk_tf;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int len, pos, tick;
    logic [FL-1:0] c, cur;
    logic arr, hold;
    logic [31:0] rnd;

    vecs[0] = '{8'h00, 8'h01, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{8'h20, 8'h01, 1'b0, 1'b0, 8'h20, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 8'h01, 1'b0, 1'b0, 8'h20, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{8'h00, 8'h01, 1'b0, 1'b0, 8'h20, 8'h20, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{8'h00, 8'h04, 1'b0, 1'b0, 8'h20, 8'h20, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{8'h00, 8'h08, 1'b1, 1'b0, 8'h20, 8'h20, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h20, 8'h20, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{8'h00, 8'h20, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{8'h20, 8'h20, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    doReset();
    checkResetValues("reset");

    // Long quiet period.
    car = 8'h10;
    for (int i = 0; i < 200; i++) applyStimulus('0, car, 1'b0, 1'b0);
`ifdef ELC_SCHED_PARKING_EN
    waitTarget("park", 8'h01, 1'b0);
    finishTrip("park", 8'h01);
`else
    checkOutput("quiet_idle", int'(idle), 1);
    checkOutput("quiet_valid", int'(target_valid), 0);
    checkOutput("quiet_pending", int'(pending), 0);
`endif

    // Single call from floor 0 to floor 5, with ignored arrivals along the way.
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].call, vecs[i].cur, vecs[i].arr, vecs[i].hold);
      checkOutput($sformatf("vec%0d_pending", i), int'(pending), int'(vecs[i].e_pend));
      checkOutput($sformatf("vec%0d_valid", i), int'(target_valid), int'(vecs[i].e_tv));
      checkOutput($sformatf("vec%0d_dir", i), int'(dir_up), int'(vecs[i].e_dir));
      checkOutput($sformatf("vec%0d_dwell", i), int'(dwell), int'(vecs[i].e_dwell));
      checkOutput($sformatf("vec%0d_idle", i), int'(idle), int'(vecs[i].e_idle));
      if (vecs[i].chk_tf)
        checkOutput($sformatf("vec%0d_target", i), int'(target_floor), int'(vecs[i].e_tf));
    end
    car = 8'h20;
    waitDwell(2, 0, 0, '0, len);
    checkOutput("single_dwell_len", len, DWELL);
    checkOutput("single_end_idle", int'(idle), 1);
    checkOutput("single_end_pending", int'(pending), 0);

    // SCAN order: from floor 3 going up with calls at 7, 2, 0.
    car = 8'h08;
    applyStimulus(8'h85, car, 1'b0, 1'b0);
    checkOutput("scan_pending", int'(pending), 8'h85);
    waitTarget("scan1", 8'h80, 1'b1);
    finishTrip("scan1", 8'h80);
    waitTarget("scan2", 8'h04, 1'b0);
    finishTrip("scan2", 8'h04);
    waitTarget("scan3", 8'h01, 1'b0);
    finishTrip("scan3", 8'h01);
    checkOutput("scan_end_idle", int'(idle), 1);

    // Retarget toward a call picked up on the way.
    car = 8'h02;
    applyStimulus(8'h40, car, 1'b0, 1'b0);
    waitTarget("retgt_first", 8'h40, 1'b1);
    applyStimulus(8'h08, car, 1'b0, 1'b0);
    checkOutput("retgt_pending", int'(pending), 8'h48);
    applyStimulus('0, car, 1'b0, 1'b0);
    checkOutput("retgt_target", int'(target_floor), 8'h08);
    checkOutput("retgt_dir", int'(dir_up), 1);
    checkOutput("retgt_still_pending", int'(pending & 8'h40), 8'h40);
    finishTrip("retgt_stop", 8'h08);
    waitTarget("retgt_second", 8'h40, 1'b1);
    finishTrip("retgt_second", 8'h40);

    // Door hold stretches the dwell; same-floor call during dwell is absorbed.
    applyStimulus(8'h04, car, 1'b0, 1'b0);
    waitTarget("hold", 8'h04, 1'b0);
    car = 8'h04;
    applyStimulus('0, car, 1'b1, 1'b0);
    waitDwell(1, 4, 10, 8'h04, len);
    checkOutput("hold_dwell_len", len, DWELL + 10);
    checkOutput("hold_pending", int'(pending), 0);
    checkOutput("hold_idle", int'(idle), 1);

    // Reset while moving with every floor pending.
    applyStimulus(8'hFF, car, 1'b0, 1'b0);
    waitTarget("rst_move", 8'h02, 1'b0);
    reset = 1'b1;
    applyStimulus('0, car, 1'b0, 1'b0);
    reset = 1'b0;
    checkResetValues("rst_mid_move");
    applyStimulus(8'h02, car, 1'b0, 1'b0);
    waitTarget("resume", 8'h02, 1'b0);
    finishTrip("resume", 8'h02);
    checkOutput("resume_idle", int'(idle), 1);

    // Randomized run against the reference model with a simple car.
    doReset();
    modelReset();
    pos  = 0;
    tick = 0;
    for (int i = 0; i < 3000; i++) begin
      tick++;
      rnd = $urandom;
      c   = ($urandom_range(0, 7) == 0) ? rnd[7:0] : '0;
      if (m_mode == M_TRAVEL && tick % 2 == 0 && pos != m_tgt)
        pos += (m_tgt > pos) ? 1 : -1;
      cur = 8'h01 << pos;
      if ($urandom_range(0, 29) == 0) cur = (rnd[8]) ? '0 : (cur | rnd[15:8]);
      arr  = (m_mode == M_TRAVEL && pos == m_tgt && $urandom_range(0, 3) != 0) ||
             ($urandom_range(0, 19) == 0);
      hold = (m_mode == M_DOORS) && ($urandom_range(0, 5) == 0);
      applyStimulus(c, cur, arr, hold);
      modelStep(c, cur, arr, hold);
      checkModel();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
